// File: rtl/cannon_pkg.sv
// Shared types and constants for the Cannon multiply array.
package cannon_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CALC,
      DRAIN,
      DONE
   } state_e;

   localparam int CANNON_N = 4;

   function automatic int step_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cannon_seq_ctrl.sv
// Job sequencer for the Cannon array: operand load, N MAC steps,
// pipeline drain, then result hold until the consumer accepts it.
module cannon_seq_ctrl
   import cannon_pkg::*;
#(
   parameter int N       = CANNON_N,
   parameter int MAC_LAT = 1,
   parameter int CNT_W   = 16,
   localparam int SW     = step_w(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             abort,
   output logic             unit_load,
   output logic             unit_en,
   output logic [SW-1:0]    step,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] job_cnt
);

   // Step and drain share one counter, wide enough for either use.
   localparam int CW = (SW > 3) ? SW : 3;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] jobs_q, jobs_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         jobs_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         jobs_q  <= jobs_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      jobs_d  = jobs_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && !abort) state_d = LOAD;
         end
         LOAD: begin
            state_d = CALC;
            cnt_d   = '0;
         end
         CALC: begin
            if (cnt_q == CW'(N - 1)) begin
               cnt_d   = '0;
               state_d = (MAC_LAT > 0) ? DRAIN : DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (cnt_q == CW'(MAC_LAT - 1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
               jobs_d  = jobs_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      // Abort beats every other transition, including the result handshake.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = '0;
         jobs_d  = jobs_q;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign unit_load = (state_q == LOAD);
   assign unit_en   = (state_q == CALC);
   assign step      = unit_en ? SW'(cnt_q) : '0;
   assign busy      = (state_q == LOAD) || (state_q == CALC)
                   || (state_q == DRAIN);
   assign res_valid = (state_q == DONE);
   assign job_cnt   = jobs_q;

endmodule

// File: doc/cannon_seq_ctrl.md
Name: cannon_seq_ctrl

Overview:
- Sequencer for the N x N Cannon multiply array.
- Accepts a job command, pulses the one-cycle operand load to the processing units, and enables N shift/MAC cycles.
- Waits out the MAC pipeline latency, then holds a result-valid flag until the consumer accepts the result.
- Replaces the ad-hoc state logic inside the array top; the array top instantiates this block and wires unit_load/unit_en to every cannon_unit.

Parameters:
- N, 4, array dimension; number of shift/MAC steps per job; legal range 2..16.
- MAC_LAT, 1, cycles between the last unit_en and the units' sums being stable; legal range 0..7.
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  job request; operands A/B are stable at the array inputs while asserted.
- cmd_ready  output  1  controller can accept a job; high only in IDLE.
- abort  input  1  cancel the current job.
- unit_load  output  1  one-cycle pulse; units latch skewed operands and clear their accumulators.
- unit_en  output  1  units shift A left / B up and accumulate.
- step  output  $clog2(N)  index of the current MAC step; 0 outside CALC.
- busy  output  1  high in LOAD, CALC and DRAIN.
- res_valid  output  1  sums at the array outputs are final.
- res_ready  input  1  consumer accepts the result.
- job_cnt  output  CNT_W  number of completed jobs; wraps modulo 2^CNT_W.

Behaviour:
- Outputs are Moore, decoded from the registered state and counters; there are no combinational paths from inputs to outputs.
- Reset: state goes to IDLE on any clock edge with rst=1, overriding everything else.
  - After reset: unit_load=0, unit_en=0, step=0, busy=0, res_valid=0, job_cnt=0, cmd_ready=1.
- State IDLE:
  - cmd_ready=1.
  - If cmd_valid=1 on an edge and abort=0, go to LOAD; the handshake edge is T.
- State LOAD (cycle T+1):
  - unit_load=1, busy=1.
  - Next state is CALC with step counter = 0.
- State CALC (cycles T+2 .. T+N+1):
  - unit_en=1, busy=1, step = 0,1,..,N-1.
  - After step N-1: go to DRAIN if MAC_LAT>0, otherwise go to DONE.
- State DRAIN (MAC_LAT cycles):
  - busy=1, unit_en=0.
  - The drain counter reuses the step register internally; the step output is forced to 0 during DRAIN.
  - After MAC_LAT cycles, go to DONE.
- State DONE:
  - res_valid=1, busy=0, cmd_ready=0.
  - Hold in DONE until res_ready=1 on an edge.
  - On that edge: increment job_cnt and return to IDLE.
- Result latency: res_valid is first high in cycle T+N+2+MAC_LAT (T+7 for defaults).
- Back-to-back: cmd_ready is low in DONE, so a new job cannot be accepted before the cycle after the result handshake. Minimum job spacing is N+3+MAC_LAT cycles, assuming res_ready is held high.
- A cmd_valid held high while not in IDLE is ignored and causes no error. It is accepted on the first IDLE edge.
- Abort:
  - abort=1 in LOAD, CALC, DRAIN or DONE: next state is IDLE, step clears, job_cnt is unchanged, and no res_valid is produced.
  - abort=1 in IDLE blocks acceptance of a job on that edge.
  - If abort and res_ready are both 1 in DONE, abort wins and job_cnt does not increment.
- rst and abort both high: rst wins; job_cnt clears.
- job_cnt wraps from 2^CNT_W-1 to 0 and has no sticky overflow flag.
- unit_load and unit_en are never high in the same cycle.

Decomposition:
- Shared package cannon_pkg holds:
  - the state enum {IDLE, LOAD, CALC, DRAIN, DONE};
  - the default array dimension constant CANNON_N=4;
  - a function returning the step width for a given N.
- The array top and this controller both import cannon_pkg.
- No sub-module is needed; the step/drain counter and the job counter stay inline.

Test Plan:
- Reset then single job: rst for 2 cycles, cmd_valid at edge T=5, res_ready=1.
  - Required: unit_load high only in cycle 6; unit_en high in cycles 7-10 with step 0,1,2,3; busy cycles 6-11; res_valid in cycle 12; job_cnt=1 at cycle 13.
- Consumer backpressure: res_ready=0 for 10 cycles after res_valid.
  - Required: res_valid and cmd_ready=0 held for all 10 cycles; job_cnt increments only on the res_ready edge.
- Back-to-back: cmd_valid held high, res_ready=1.
  - Required: second unit_load exactly 8 cycles after the first (N=4, MAC_LAT=1); job_cnt=2 after two results.
- Abort in the middle of CALC at step 2:
  - Required: next cycle IDLE with unit_en=0 and step=0; res_valid never asserted; job_cnt unchanged.
  - A new job then completes normally.
- Corner cases:
  - abort and res_ready together in DONE: return to IDLE with job_cnt unchanged.
  - rst asserted in DRAIN: all outputs take reset values on the next cycle.
  - MAC_LAT=0 build: res_valid follows the last unit_en cycle directly.
- Counter wrap: CNT_W=4 build, 17 jobs.
  - Required: job_cnt reads 15 then 0 then 1.
